lsu_seq: RTL and testbench

Load/store sequencer between the core's execute stage and a data memory with a variable-latency request/acknowledge interface. Captures one memory operation (byte/half/word, signed/unsigned load, sub-word store), issues the word-aligned memory transactions, and returns the extended load result. Sub-word stores become read-modify-write because the data memory has no byte enables. The core stalls on `busy` and consumes the result on the `done` pulse.

---
 rtl/lsu_seq_pkg.sv | 40 ++++
 rtl/lsu_extract.sv | 38 +++
 rtl/lsu_seq.sv | 172 +++++++++++++++++
 tb/tb_lsu_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_seq_pkg.sv
// Shared opcode and state encodings for the load/store sequencer,
// plus small opcode classification helpers.
package lsu_seq_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned CNT_W = 16;

    // Codes above MEM_SW behave as MEM_NONE and are never accepted.
    function automatic logic op_is_mem(input logic [3:0] op);
        return (op != MEM_NONE) && (op <= MEM_SW);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic w_half;
        logic w_word;
        w_half = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        w_word = (op == MEM_LW) || (op == MEM_SW);
        return (w_half && off[0]) || (w_word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// Load lane select and sign/zero extension of a memory word.
module lsu_extract
    import lsu_seq_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = '0;
        case (i_op)
            MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: o_data = {24'd0, w_byte};
            MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: o_data = {16'd0, w_half};
            MEM_LW:  o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: issues word-aligned memory transactions for one
// captured operation, doing read-modify-write for sub-word stores.
module lsu_seq
    import lsu_seq_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        timeout,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam logic [CNT_W-1:0] LP_LIMIT = 16'(ACK_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_op;
    logic [1:0]       r_off;
    logic [15:0]      r_sdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_load_data;
    logic             r_misalign;
    logic             r_timeout;
    logic             r_dm_req;
    logic             r_dm_we;
    logic [31:0]      r_dm_addr;
    logic [31:0]      r_dm_wdata;

    logic [31:0]      w_ext;
    logic [31:0]      w_merged;

    lsu_extract u_extract (
        .i_word (dm_rdata),
        .i_off  (r_off),
        .i_op   (r_op),
        .o_data (w_ext)
    );

    always_comb begin
        w_merged = dm_rdata;
        if (r_op == MEM_SB) begin
            case (r_off)
                2'd0:    w_merged[7:0]   = r_sdata[7:0];
                2'd1:    w_merged[15:8]  = r_sdata[7:0];
                2'd2:    w_merged[23:16] = r_sdata[7:0];
                default: w_merged[31:24] = r_sdata[7:0];
            endcase
        end else if (r_op == MEM_SH) begin
            if (r_off[1]) w_merged[31:16] = r_sdata;
            else          w_merged[15:0]  = r_sdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= MEM_NONE;
            r_off       <= '0;
            r_sdata     <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_load_data <= '0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
            r_dm_req    <= 1'b0;
            r_dm_we     <= 1'b0;
            r_dm_addr   <= '0;
            r_dm_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid && op_is_mem(mem_op)) begin
                        r_op    <= mem_op;
                        r_off   <= addr[1:0];
                        r_sdata <= st_data[15:0];
                        r_busy  <= 1'b1;
                        if (op_misaligned(mem_op, addr[1:0])) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                        end else begin
                            r_cnt     <= '0;
                            r_dm_req  <= 1'b1;
                            r_dm_addr <= {addr[31:2], 2'b00};
                            if (mem_op == MEM_SW) begin
                                r_state    <= ST_WR;
                                r_dm_we    <= 1'b1;
                                r_dm_wdata <= st_data;
                            end else begin
                                r_state <= ST_RD;
                                r_dm_we <= 1'b0;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (dm_ack) begin
                        if (op_is_load(r_op)) begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_dm_req    <= 1'b0;
                            r_load_data <= w_ext;
                        end else begin
                            // RMW: request stays high, only direction and data change.
                            r_state    <= ST_WR;
                            r_cnt      <= '0;
                            r_dm_we    <= 1'b1;
                            r_dm_wdata <= w_merged;
                        end
                    end else if (r_cnt == LP_LIMIT) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_dm_req  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    if (dm_ack) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_dm_req <= 1'b0;
                    end else if (r_cnt == LP_LIMIT) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_dm_req  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_misalign  <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_load_data <= '0;
                    r_dm_we     <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign load_data = r_load_data;
    assign misalign  = r_misalign;
    assign timeout   = r_timeout;
    assign dm_req    = r_dm_req;
    assign dm_we     = r_dm_we;
    assign dm_addr   = r_dm_addr;
    assign dm_wdata  = r_dm_wdata;

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: directed vector table, randomized ops
// against an arithmetic reference model, and reset/invalid-op sequences.
module tb_lsu_seq;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misalign;
    logic        timeout;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    lsu_seq #(.ACK_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .mem_op    (mem_op),
        .addr      (addr),
        .st_data   (st_data),
        .busy      (busy),
        .done      (done),
        .load_data (load_data),
        .misalign  (misalign),
        .timeout   (timeout),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] mw;
        int          dly;
        bit          nev;
        int          e_done;
        logic [31:0] e_ld;
        bit          e_mis;
        bit          e_to;
        bit          e_wr;
        logic [31:0] e_wd;
        int          e_reqc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    int          res_done;
    logic [31:0] res_ld;
    bit          res_mis, res_to, res_wrote;
    logic [31:0] res_waddr, res_wdata;
    int          res_reqc;
    bit          res_busy_ok, res_stable_ok, res_addr_ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one op and plays the memory: ack after dly wait cycles per access.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] mw, input int dly, input bit nev);
        int          w;
        logic        preq, pwe;
        logic [31:0] paddr, pwd;
        res_done = -1; res_ld = '0; res_mis = 0; res_to = 0; res_wrote = 0;
        res_waddr = '0; res_wdata = '0; res_reqc = 0;
        res_busy_ok = 1; res_stable_ok = 1; res_addr_ok = 1;
        op_valid = 1'b1; mem_op = op; addr = a; st_data = sd;
        dm_ack = 1'($urandom % 2); dm_rdata = $urandom;
        preq = 0; pwe = 0; paddr = '0; pwd = '0; w = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            dm_ack = 1'b0; dm_rdata = $urandom;
            // Inputs after the latch must be ignored.
            addr = $urandom; st_data = $urandom; mem_op = 4'($urandom);
            if (!busy) res_busy_ok = 0;
            if (dm_req) begin
                res_reqc++;
                if (dm_addr != {a[31:2], 2'b00}) res_addr_ok = 0;
                if (!preq || dm_we != pwe) w = 0;
                else if (dm_addr != paddr || dm_wdata != pwd) res_stable_ok = 0;
            end
            if (done) begin
                res_done = cyc; res_ld = load_data; res_mis = misalign; res_to = timeout;
                break;
            end
            if (dm_req) begin
                if (!nev && w == dly) begin
                    dm_ack = 1'b1;
                    if (dm_we) begin
                        res_wrote = 1; res_waddr = dm_addr; res_wdata = dm_wdata;
                    end else begin
                        dm_rdata = mw;
                    end
                end
                w++;
            end else begin
                dm_ack = 1'($urandom % 2);
            end
            preq = dm_req; pwe = dm_we; paddr = dm_addr; pwd = dm_wdata;
        end
        op_valid = 1'b0;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        run_op(v.op, v.a, v.sd, v.mw, v.dly, v.nev);
        chk({tag, "_done_cycle"}, 32'(res_done), 32'(v.e_done));
        chk({tag, "_load_data"}, res_ld, v.e_ld);
        chk({tag, "_misalign"}, 32'(res_mis), 32'(v.e_mis));
        chk({tag, "_timeout"}, 32'(res_to), 32'(v.e_to));
        chk({tag, "_wrote"}, 32'(res_wrote), 32'(v.e_wr));
        chk({tag, "_req_cycles"}, 32'(res_reqc), 32'(v.e_reqc));
        chk({tag, "_busy_held"}, 32'(res_busy_ok), 32'd1);
        chk({tag, "_req_stable"}, 32'(res_stable_ok), 32'd1);
        chk({tag, "_dm_addr"}, 32'(res_addr_ok), 32'd1);
        if (v.e_wr) begin
            chk({tag, "_wdata"}, res_wdata, v.e_wd);
            chk({tag, "_waddr"}, res_waddr, v.a & 32'hFFFF_FFFC);
        end
    endtask

    // Reference: sizes, shifts and masks straight from the operation rules.
    function automatic vec_t model(input vec_t v);
        int          sz;
        int          sh;
        logic [31:0] x;
        logic [31:0] mask;
        vec_t        r;
        r = v;
        r.e_ld = '0; r.e_mis = 0; r.e_to = 0; r.e_wr = 0; r.e_wd = '0;
        if (v.op == 4'd2 || v.op == 4'd5 || v.op == 4'd7) sz = 2;
        else if (v.op == 4'd3 || v.op == 4'd8) sz = 4;
        else sz = 1;
        if (int'(v.a[1:0]) % sz != 0) begin
            r.e_mis = 1; r.e_done = 1; r.e_reqc = 0;
            return r;
        end
        if (v.nev) begin
            r.e_to = 1; r.e_done = 1 + TMO; r.e_reqc = TMO;
            return r;
        end
        sh = 8 * int'(v.a[1:0]);
        x  = v.mw >> sh;
        if (v.op == 4'd6 || v.op == 4'd7) begin
            mask   = (sz == 1 ? 32'hFF : 32'hFFFF) << sh;
            r.e_wr = 1;
            r.e_wd = (v.mw & ~mask) | ((v.sd << sh) & mask);
            r.e_done = 3 + 2 * v.dly; r.e_reqc = 2 * (v.dly + 1);
        end else begin
            r.e_done = 2 + v.dly; r.e_reqc = v.dly + 1;
            case (v.op)
                4'd1: r.e_ld = (x & 32'hFF) - ((x & 32'h80) << 1);
                4'd2: r.e_ld = (x & 32'hFFFF) - ((x & 32'h8000) << 1);
                4'd3: r.e_ld = v.mw;
                4'd4: r.e_ld = x & 32'hFF;
                4'd5: r.e_ld = x & 32'hFFFF;
                default: begin
                    r.e_wr = 1; r.e_wd = v.sd;
                end
            endcase
        end
        return r;
    endfunction

    vec_t tbl[12];

    initial begin
        bit acc;
        vec_t v;
        tbl[0]  = '{4'd3, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 2, 32'hDEADBEEF, 0, 0, 0, 32'h0, 1};
        tbl[1]  = '{4'd1, 32'h103, 32'h0,        32'h80FF7F01, 3, 0, 5, 32'hFFFFFF80, 0, 0, 0, 32'h0, 4};
        tbl[2]  = '{4'd4, 32'h103, 32'h0,        32'h80FF7F01, 3, 0, 5, 32'h00000080, 0, 0, 0, 32'h0, 4};
        tbl[3]  = '{4'd7, 32'h202, 32'h1234ABCD, 32'h11223344, 0, 0, 3, 32'h0, 0, 0, 1, 32'hABCD3344, 2};
        tbl[4]  = '{4'd3, 32'h101, 32'h0,        32'h0,        0, 0, 1, 32'h0, 1, 0, 0, 32'h0, 0};
        tbl[5]  = '{4'd2, 32'h103, 32'h0,        32'h0,        0, 0, 1, 32'h0, 1, 0, 0, 32'h0, 0};
        tbl[6]  = '{4'd8, 32'h300, 32'hCAFEF00D, 32'h0,        0, 1, 5, 32'h0, 0, 1, 0, 32'h0, 4};
        tbl[7]  = '{4'd2, 32'h102, 32'h0,        32'h80017FFF, 1, 0, 3, 32'hFFFF8001, 0, 0, 0, 32'h0, 2};
        tbl[8]  = '{4'd5, 32'h100, 32'h0,        32'h12349876, 0, 0, 2, 32'h00009876, 0, 0, 0, 32'h0, 1};
        tbl[9]  = '{4'd6, 32'h401, 32'h000000AA, 32'h11223344, 2, 0, 7, 32'h0, 0, 0, 1, 32'h1122AA44, 6};
        tbl[10] = '{4'd6, 32'h500, 32'h000000AA, 32'h11223344, 0, 1, 5, 32'h0, 0, 1, 0, 32'h0, 4};
        tbl[11] = '{4'd8, 32'h602, 32'h55555555, 32'h0,        0, 0, 1, 32'h0, 1, 0, 0, 32'h0, 0};

        rst_n = 1'b0; op_valid = 1'b0; mem_op = '0; addr = '0; st_data = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        #12;
        chk("reset_ctrl", {26'd0, busy, done, misalign, timeout, dm_req, dm_we}, 32'd0);
        chk("reset_dm_addr", dm_addr, 32'd0);
        chk("reset_dm_wdata", dm_wdata, 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) check_vec($sformatf("vec%0d", i), tbl[i]);

        // Invalid opcodes must not start an operation.
        acc = 0;
        op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_op = (i % 2 == 0) ? 4'd9 : 4'd0;
            @(posedge clk); #1;
            acc = acc | busy | dm_req | done;
        end
        mem_op = 4'd15;
        @(posedge clk); #1;
        acc = acc | busy | dm_req | done;
        op_valid = 1'b0;
        chk("invalid_op_ignored", 32'(acc), 32'd0);

        // Reset during an SB read wait abandons the request.
        op_valid = 1'b1; mem_op = 4'd6; addr = 32'h704; st_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("rmw_in_flight_req", {31'd0, dm_req}, 32'd1);
        rst_n = 1'b0; op_valid = 1'b0;
        #1;
        chk("async_reset_outputs", {29'd0, dm_req, busy, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_vec("post_reset_lw", tbl[0]);

        for (int n = 0; n < 40; n++) begin
            v.op  = 4'($urandom_range(1, 8));
            v.a   = $urandom;
            if ($urandom_range(0, 3) != 0) v.a[0] = 1'b0;
            if ($urandom_range(0, 1) != 0) v.a[1] = 1'b0;
            v.sd  = $urandom;
            v.mw  = $urandom;
            v.dly = $urandom_range(0, 3);
            v.nev = ($urandom_range(0, 7) == 0);
            v = model(v);
            check_vec($sformatf("rnd%0d_op%0d", n, v.op), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
